// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the EX stage and the shift sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             START;
  logic             FLUSH;
  logic [1:0]       OP;
  logic [4:0]       SHAMT;
  logic [WIDTH-1:0] DATA_IN;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;

  modport master (
    output START, FLUSH, OP, SHAMT, DATA_IN,
    input  BUSY, DONE, RESULT
  );

  modport slave (
    input  START, FLUSH, OP, SHAMT, DATA_IN,
    output BUSY, DONE, RESULT
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/LUI unit: walks the shift amount one
// power-of-two step per cycle (16/8/4/2/1) on an internal accumulator.
module shift_sequencer #(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  shift_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_LUI = 2'b11;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;

  logic [4:0]       step;
  logic [WIDTH-1:0] shifted;

  // Isolate the highest set bit of the remaining amount; its value is the step size.
  always_comb begin
    step = 5'd0;
    if      (rem_q[4]) step = 5'd16;
    else if (rem_q[3]) step = 5'd8;
    else if (rem_q[2]) step = 5'd4;
    else if (rem_q[1]) step = 5'd2;
    else if (rem_q[0]) step = 5'd1;
  end

  // One step of the accumulator in the latched direction; SRA replicates acc[MSB].
  always_comb begin
    unique case (op_q)
      OP_SRL:  shifted = acc_q >> step;
      OP_SRA:  shifted = $unsigned($signed(acc_q) >>> step);
      default: shifted = acc_q << step;
    endcase
  end

  // Next-state and datapath updates; FLUSH beats both START and completion.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    op_d     = op_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.START && !bus.FLUSH) begin
          state_d = SHIFT;
          if (bus.OP == OP_LUI) begin
            // LUI is just a fixed SLL of the low halfword.
            acc_d = {{(WIDTH-16){1'b0}}, bus.DATA_IN[15:0]};
            rem_d = LUI_SHIFT[4:0];
            op_d  = OP_SLL;
          end else begin
            acc_d = bus.DATA_IN;
            rem_d = bus.SHAMT;
            op_d  = bus.OP;
          end
        end
      end
      SHIFT: begin
        if (bus.FLUSH) begin
          state_d = IDLE;
        end else if (rem_q != 5'd0) begin
          acc_d = shifted;
          rem_d = rem_q & ~step;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (!bus.FLUSH) begin
          result_d = acc_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.BUSY   = (state_q != IDLE);
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected result and completion
// cycle are queued at START acceptance and checked when DONE fires.
module tb_shift_sequencer;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  shift_sequencer_if #(.WIDTH(32)) bus();

  shift_sequencer #(.WIDTH(32), .LUI_SHIFT(16)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [4:0] sh,
                                        input logic [31:0] d);
    case (op)
      2'b00:   model = d << sh;
      2'b01:   model = d >> sh;
      2'b10:   model = $unsigned($signed(d) >>> sh);
      default: model = {d[15:0], 16'h0000};
    endcase
  endfunction

  function automatic int lat(input logic [1:0] op, input logic [4:0] sh);
    lat = ((op == 2'b11) ? 1 : $countones(sh)) + 2;
  endfunction

  // Monitor: count BUSY cycles, pop/compare on each DONE.
  always @(negedge CLK) begin
    exp_t e;
    if (bus.BUSY) busy_cnt++;
    if (bus.DONE) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", bus.RESULT, e.res);
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Assumes caller sits just after a posedge with the DUT idle; leaves
  // the bench just after the accepting edge with operands scrambled.
  task automatic run(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] d,
                     input bit push);
    exp_t e;
    bus.START   = 1'b1;
    bus.OP      = op;
    bus.SHAMT   = sh;
    bus.DATA_IN = d;
    @(posedge CLK); #1;
    if (push) begin
      e.res = model(op, sh, d);
      e.cyc = cyc + lat(op, sh);
      sb.push_back(e);
    end
    bus.START   = 1'b0;
    bus.OP      = 2'($urandom);
    bus.SHAMT   = 5'($urandom);
    bus.DATA_IN = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || bus.BUSY) && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    logic [1:0] rop;
    logic [4:0] rsh;
    bus.START = 1'b0; bus.FLUSH = 1'b0; bus.OP = 2'b00;
    bus.SHAMT = 5'd0; bus.DATA_IN = 32'h0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_result", bus.RESULT, 32'h0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;

    // Directed operations
    busy_cnt = 0;
    run(2'b00, 5'd31, 32'h0000_0001, 1'b1);
    wait_idle();
    chk("sll31_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("sll31_value", bus.RESULT, 32'h8000_0000);
    run(2'b10, 5'd4, 32'h8000_0000, 1'b1); wait_idle();
    chk("sra4_value", bus.RESULT, 32'hF800_0000);
    run(2'b01, 5'd4, 32'h8000_0000, 1'b1); wait_idle();
    chk("srl4_value", bus.RESULT, 32'h0800_0000);
    run(2'b11, 5'd7, 32'hABCD_1234, 1'b1); wait_idle();
    chk("lui_value", bus.RESULT, 32'h1234_0000);
    run(2'b01, 5'd0, 32'hDEAD_BEEF, 1'b1); wait_idle();
    chk("srl0_value", bus.RESULT, 32'hDEAD_BEEF);
    run(2'b10, 5'd13, 32'h8000_0010, 1'b1); wait_idle();

    // Random operations
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom);
      rsh = 5'($urandom);
      run(rop, rsh, $urandom, 1'b1);
      wait_idle();
    end

    // START while busy is ignored
    run(2'b00, 5'd3, 32'h1, 1'b1);
    bus.START = 1'b1; bus.OP = 2'b01; bus.SHAMT = 5'd1; bus.DATA_IN = 32'hFFFF;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    wait_idle();
    chk("busy_start_value", bus.RESULT, 32'h8);

    // FLUSH during SHIFT: no DONE, RESULT held
    run(2'b00, 5'd3, 32'h1, 1'b0);
    @(posedge CLK); #1;
    bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    chk("flush_shift_busy", 32'(bus.BUSY), 32'd0);
    repeat (6) @(posedge CLK);
    #1;
    chk("flush_shift_result", bus.RESULT, 32'h8);

    // FLUSH in FINISH beats completion
    run(2'b00, 5'd0, 32'h5, 1'b0);
    @(posedge CLK); #1;
    bus.FLUSH = 1'b1;
    @(posedge CLK); #1;
    bus.FLUSH = 1'b0;
    chk("flush_finish_busy", 32'(bus.BUSY), 32'd0);
    repeat (4) @(posedge CLK);
    #1;
    chk("flush_finish_result", bus.RESULT, 32'h8);

    // FLUSH with START in IDLE: START ignored
    bus.START = 1'b1; bus.FLUSH = 1'b1; bus.OP = 2'b00; bus.SHAMT = 5'd1;
    @(posedge CLK); #1;
    bus.START = 1'b0; bus.FLUSH = 1'b0;
    chk("flush_start_busy", 32'(bus.BUSY), 32'd0);

    // Back-to-back: new START in the DONE cycle is accepted
    run(2'b00, 5'd1, 32'h1, 1'b1);
    n = 0;
    while (!bus.DONE && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("b2b_done_seen", 32'(bus.DONE), 32'd1);
    run(2'b01, 5'd8, 32'h100, 1'b1);
    chk("b2b_busy", 32'(bus.BUSY), 32'd1);
    wait_idle();
    chk("b2b_value", bus.RESULT, 32'h1);

    // Asynchronous reset mid-SHIFT
    run(2'b00, 5'd31, 32'hFFFF_FFFF, 1'b0);
    @(posedge CLK); #1;
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.BUSY), 32'd0);
    chk("arst_done", 32'(bus.DONE), 32'd0);
    chk("arst_result", bus.RESULT, 32'h0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("arst_idle", 32'(bus.BUSY), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
